decomp_stage1_decoder: RTL and testbench
========================================

Name: decomp_stage1_decoder

Overview:
- Decompressor counterpart of the Stage-1 compressor. Consumes one MSB-aligned code per accepted beat and rebuilds the original 32-bit word.
- Keeps its own 16-entry FIFO dictionary, updated in lockstep with the encoder's dictionary so that indexed codes resolve identically.
- Sits between the code-unpacker (upstream) and the word sink (downstream). Uses a valid/ready handshake on both sides.

Parameters:
- DICT_DEPTH, 16: dictionary entries; fixed power of two. Index width = 4.
- WORD_W, 32: decompressed word width.
- CODE_W, 34: width of the MSB-aligned code field; equals the longest code.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- code_valid_i  in  1  upstream code valid.
- code_ready_o  out  1  decoder can accept a code.
- code_i  in  34  code, MSB-aligned; bits below the code length are don't-care.
- word_valid_o  out  1  decoded word valid.
- word_ready_i  in  1  downstream accepts the word.
- word_o  out  32  decoded word.
- err_o  out  1  registered with word_o; high when the beat carried a reserved code.
- dictionary_o  out  512  dictionary mirror; entry k occupies [32k+31:32k].

Behaviour:
- Code decode, by prefix at code_i[33:...]:
  - 00 = ZZZZ → word 0x00000000.
  - 01 = literal; word = code_i[31:0].
  - 10 = MMMM; idx = code_i[31:28]; word = dict[idx].
  - 1100 = MMXX; idx = [29:26], hw = [25:10]; word = {dict[idx][31:16], hw}.
  - 1101 = ZZZX; byte = [29:22]; word = {24'h0, byte}.
  - 1110 = MMMX; idx = [29:26], byte = [25:18]; word = {dict[idx][31:8], byte}.
  - 1111 = reserved; word = 0, err = 1.
- Handshake:
  - code_ready_o = !word_valid_o || word_ready_i (combinational).
  - Accept occurs when code_valid_i && code_ready_o.
  - Latency is 1 cycle: word_o, err_o and word_valid_o are registered on the accept edge.
  - With no accept while word_ready_i is high, word_valid_o clears.
  - word_o and err_o stay stable while word_valid_o && !word_ready_i.
  - Full throughput: one word per cycle when downstream is always ready.
- Dictionary update:
  - On accept of a literal, MMXX or MMMX code, the decoded word is written to dict[wr_ptr] and wr_ptr increments.
  - wr_ptr is 4 bits and wraps 15→0.
  - ZZZZ, ZZZX, MMMM and reserved codes do not update the dictionary.
  - The lookup for the current code uses pre-update dictionary contents. A code on the next cycle sees the new entry, so back-to-back dependent codes must decode correctly.
  - An idx equal to wr_ptr reads the old entry; the write happens on the same edge.
- Reset (asynchronous, while asserted):
  - word_valid_o=0, word_o=0, err_o=0.
  - All dict entries = 0, wr_ptr=0.
  - code_ready_o resolves to 1.
  - Reset mid-stream discards the held word. The encoder must reset together with the decoder.
- No X propagation: don't-care bits of code_i must not reach word_o.

Optional Feature:
- Macro DECOMP_ERR_CNT_EN.
- Defined: adds output err_cnt_o[15:0], a saturating count of accepted reserved codes. It resets to 0 and holds at 0xFFFF.
- Undefined: the port and counter are absent; err_o remains the only error indication.

Decomposition:
- Shared package decomp_pkg:
  - code_type_e enum: ZZZZ, LIT, MMMM, MMXX, ZZZX, MMMX, RSVD.
  - Prefix constants.
  - DICT_DEPTH, WORD_W, CODE_W.
  - Field-offset localparams.
- Sub-module code_classifier: combinational; code_i → code_type_e, idx, payload byte/halfword. Reused by the compressor-side checker.
- Top holds the dictionary, wr_ptr, output register and handshake.

Test Plan:
- Literal then MMMM: code {01, 0xDEADBEEF}, then {10, 0000} → words 0xDEADBEEF, then 0xDEADBEEF; dict[0]=0xDEADBEEF, wr_ptr=1.
- ZZZZ then ZZZX: 0x000000000, then {1101, 0x5A} → words 0x00000000, then 0x0000005A; err_o=0; dictionary unchanged.
- Partial matches: literal 0x12345678, then MMMX idx0 byte 0x9A, then MMXX idx0 hw 0xBEEF → 0x1234569A, then 0x1234BEEF; wr_ptr=3.
- Wrap: 17 literals 0..16 → dict[0]=16, dict[1]=1, wr_ptr=1. MMMM idx0 → word 16.
- Backpressure: hold word_ready_i=0 for 3 cycles with code_valid_i high → code_ready_o=0; word_o stable; one word per accept, no loss or duplication.
- Reserved and reset: code 1111 → word 0, err_o=1 (err_cnt_o=1 if enabled); dictionary unchanged. Assert rst_i mid-stream → word_valid_o=0 and dict zeroed immediately.

Source files
------------

// File: rtl/decomp_pkg.sv
// rtl/decomp_pkg.sv - Shared types, code prefixes and field offsets for the Stage-1 code decoder.
// Optional feature macro used by the consumers of this package: DECOMP_ERR_CNT_EN.
package decomp_pkg;

  localparam int DICT_DEPTH = 16;
  localparam int IDX_W      = 4;
  localparam int WORD_W     = 32;
  localparam int CODE_W     = 34;
  localparam int ERR_CNT_W  = 16;

  typedef enum logic [2:0] {
    ZZZZ = 3'd0,
    LIT  = 3'd1,
    MMMM = 3'd2,
    MMXX = 3'd3,
    ZZZX = 3'd4,
    MMMX = 3'd5,
    RSVD = 3'd6
  } code_type_e;

  // Two-bit prefixes, then four-bit prefixes under the 2'b11 escape.
  localparam logic [1:0] PFX_ZZZZ = 2'b00;
  localparam logic [1:0] PFX_LIT  = 2'b01;
  localparam logic [1:0] PFX_MMMM = 2'b10;
  localparam logic [1:0] PFX_LONG = 2'b11;
  localparam logic [3:0] PFX_MMXX = 4'b1100;
  localparam logic [3:0] PFX_ZZZX = 4'b1101;
  localparam logic [3:0] PFX_MMMX = 4'b1110;
  localparam logic [3:0] PFX_RSVD = 4'b1111;

  localparam int LIT_LSB       = 0;
  localparam int MMMM_IDX_LSB  = 28;
  localparam int SHORT_IDX_LSB = 26;
  localparam int MMXX_HW_LSB   = 10;
  localparam int ZZZX_BYTE_LSB = 22;
  localparam int MMMX_BYTE_LSB = 18;

  // Code types whose decoded word enters the FIFO dictionary.
  function automatic logic updates_dict(input code_type_e t);
    return (t == LIT) || (t == MMXX) || (t == MMMX);
  endfunction

endpackage

// File: rtl/code_classifier.sv
// rtl/code_classifier.sv - Combinational prefix decode of one MSB-aligned code into type and fields.
// Fields not belonging to the detected type are forced to zero so don't-care code bits never leak.
module code_classifier
  import decomp_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output code_type_e        code_type,
  output logic [IDX_W-1:0]  idx,
  output logic [7:0]        byte_val,
  output logic [15:0]       half_word,
  output logic [WORD_W-1:0] literal
);

  always_comb begin
    code_type = RSVD;
    idx       = '0;
    byte_val  = '0;
    half_word = '0;
    literal   = '0;
    case (code[CODE_W-1 -: 2])
      PFX_ZZZZ: code_type = ZZZZ;
      PFX_LIT: begin
        code_type = LIT;
        literal   = code[LIT_LSB +: WORD_W];
      end
      PFX_MMMM: begin
        code_type = MMMM;
        idx       = code[MMMM_IDX_LSB +: IDX_W];
      end
      PFX_LONG: begin
        case (code[CODE_W-1 -: 4])
          PFX_MMXX: begin
            code_type = MMXX;
            idx       = code[SHORT_IDX_LSB +: IDX_W];
            half_word = code[MMXX_HW_LSB +: 16];
          end
          PFX_ZZZX: begin
            code_type = ZZZX;
            byte_val  = code[ZZZX_BYTE_LSB +: 8];
          end
          PFX_MMMX: begin
            code_type = MMMX;
            idx       = code[SHORT_IDX_LSB +: IDX_W];
            byte_val  = code[MMMX_BYTE_LSB +: 8];
          end
          default: code_type = RSVD;
        endcase
      end
      default: code_type = RSVD;
    endcase
  end

endmodule

// File: rtl/decomp_stage1_decoder.sv
// rtl/decomp_stage1_decoder.sv - Stage-1 decoder: rebuilds 32-bit words from codes with a 16-entry FIFO dictionary.
// Optional saturating reserved-code counter port err_cnt_o is built when DECOMP_ERR_CNT_EN is defined.
module decomp_stage1_decoder
  import decomp_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         code_valid_i,
  output logic                         code_ready_o,
  input  logic [CODE_W-1:0]            code_i,
  output logic                         word_valid_o,
  input  logic                         word_ready_i,
  output logic [WORD_W-1:0]            word_o,
  output logic                         err_o,
  output logic [DICT_DEPTH*WORD_W-1:0] dictionary_o
`ifdef DECOMP_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]         err_cnt_o
`endif
);

  code_type_e        code_type;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        byte_val;
  logic [15:0]       half_word;
  logic [WORD_W-1:0] literal;

  logic [WORD_W-1:0] dict [DICT_DEPTH];
  logic [IDX_W-1:0]  wr_ptr;
  logic [WORD_W-1:0] dict_entry;
  logic [WORD_W-1:0] dec_word;
  logic              dec_err;
  logic              accept;

  code_classifier u_classifier (
    .code      (code_i),
    .code_type (code_type),
    .idx       (idx),
    .byte_val  (byte_val),
    .half_word (half_word),
    .literal   (literal)
  );

  assign code_ready_o = !word_valid_o || word_ready_i;
  assign accept       = code_valid_i && code_ready_o;

  // Lookup sees pre-update contents; a write to the same slot lands on this edge.
  assign dict_entry = dict[idx];

  always_comb begin
    dec_word = '0;
    dec_err  = 1'b0;
    case (code_type)
      ZZZZ:    dec_word = '0;
      LIT:     dec_word = literal;
      MMMM:    dec_word = dict_entry;
      MMXX:    dec_word = {dict_entry[31:16], half_word};
      ZZZX:    dec_word = {24'h0, byte_val};
      MMMX:    dec_word = {dict_entry[31:8], byte_val};
      default: dec_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_valid_o <= 1'b0;
      word_o       <= '0;
      err_o        <= 1'b0;
    end else if (accept) begin
      word_valid_o <= 1'b1;
      word_o       <= dec_word;
      err_o        <= dec_err;
    end else if (word_ready_i) begin
      word_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < DICT_DEPTH; k++) begin
        dict[k] <= '0;
      end
      wr_ptr <= '0;
    end else if (accept && updates_dict(code_type)) begin
      dict[wr_ptr] <= dec_word;
      wr_ptr       <= wr_ptr + 1'b1;
    end
  end

  for (genvar g = 0; g < DICT_DEPTH; g++) begin : g_dict_mirror
    assign dictionary_o[g*WORD_W +: WORD_W] = dict[g];
  end

`ifdef DECOMP_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt <= '0;
    end else if (accept && (code_type == RSVD) && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign err_cnt_o = err_cnt;
`endif

endmodule

// File: tb/tb_decomp_stage1_decoder.sv
// tb/tb_decomp_stage1_decoder.sv - Directed self-checking bench for decomp_stage1_decoder.
module tb_decomp_stage1_decoder;

  logic         clk;
  logic         rst;
  logic         code_valid;
  logic         code_ready;
  logic [33:0]  code;
  logic         word_valid;
  logic         word_ready;
  logic [31:0]  word;
  logic         err;
  logic [511:0] dictionary;
`ifdef DECOMP_ERR_CNT_EN
  logic [15:0]  err_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  decomp_stage1_decoder dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .code_valid_i (code_valid),
    .code_ready_o (code_ready),
    .code_i       (code),
    .word_valid_o (word_valid),
    .word_ready_i (word_ready),
    .word_o       (word),
    .err_o        (err),
    .dictionary_o (dictionary)
`ifdef DECOMP_ERR_CNT_EN
    ,
    .err_cnt_o    (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [33:0] c_lit(input logic [31:0] w);
    return {2'b01, w};
  endfunction
  function automatic logic [33:0] c_mmmm(input logic [3:0] i);
    return {2'b10, i, 28'hABC_DEF1};
  endfunction
  function automatic logic [33:0] c_mmxx(input logic [3:0] i, input logic [15:0] h);
    return {4'b1100, i, h, 10'h3A5};
  endfunction
  function automatic logic [33:0] c_zzzx(input logic [7:0] b);
    return {4'b1101, b, 22'h2F_0F0F};
  endfunction
  function automatic logic [33:0] c_mmmx(input logic [3:0] i, input logic [7:0] b);
    return {4'b1110, i, b, 18'h3_C3C3};
  endfunction

  task automatic send_code(input logic [33:0] c);
    @(negedge clk);
    code_valid = 1'b1;
    code       = c;
    word_ready = 1'b1;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    code_valid = 1'b0;
    word_ready = 1'b1;
    code       = '0;
    rst        = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", word_valid); end
    n_cmp++; if (word !== 32'h0) begin n_fail++; $display("FAIL reset_word: got %h want 0", word); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (dictionary !== 512'h0) begin n_fail++; $display("FAIL reset_dict: got nonzero dictionary want 0"); end
    n_cmp++; if (code_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", code_ready); end
    rst = 1'b0;
  endtask

  task automatic test_literal_mmmm();
    do_reset();
    send_code(c_lit(32'hDEAD_BEEF));
    n_cmp++; if (word_valid !== 1'b1 || word !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lit_word: got v=%b %h want v=1 deadbeef", word_valid, word); end
    send_code(c_mmmm(4'd0));
    n_cmp++; if (word_valid !== 1'b1 || word !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mmmm_word: got v=%b %h want v=1 deadbeef", word_valid, word); end
    n_cmp++; if (dictionary[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lit_dict0: got %h want deadbeef", dictionary[31:0]); end
    n_cmp++; if (dut.wr_ptr !== 4'd1) begin n_fail++; $display("FAIL lit_wrptr: got %0d want 1", dut.wr_ptr); end
  endtask

  task automatic test_zzzz_zzzx();
    send_code({2'b00, 32'hFFFF_FFFF});
    n_cmp++; if (word !== 32'h0 || err !== 1'b0) begin n_fail++; $display("FAIL zzzz_word: got %h err=%b want 0 err=0", word, err); end
    send_code(c_zzzx(8'h5A));
    n_cmp++; if (word !== 32'h0000_005A || err !== 1'b0) begin n_fail++; $display("FAIL zzzx_word: got %h err=%b want 0000005a err=0", word, err); end
    n_cmp++; if (dictionary !== {480'h0, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL zz_dict: got dict0=%h dict1=%h want deadbeef 0", dictionary[31:0], dictionary[63:32]); end
    n_cmp++; if (dut.wr_ptr !== 4'd1) begin n_fail++; $display("FAIL zz_wrptr: got %0d want 1", dut.wr_ptr); end
  endtask

  task automatic test_partial();
    do_reset();
    send_code(c_lit(32'h1234_5678));
    send_code(c_mmmx(4'd0, 8'h9A));
    n_cmp++; if (word !== 32'h1234_569A) begin n_fail++; $display("FAIL mmmx_word: got %h want 1234569a", word); end
    send_code(c_mmxx(4'd0, 16'hBEEF));
    n_cmp++; if (word !== 32'h1234_BEEF) begin n_fail++; $display("FAIL mmxx_word: got %h want 1234beef", word); end
    send_code(c_mmmm(4'd2));
    n_cmp++; if (word !== 32'h1234_BEEF) begin n_fail++; $display("FAIL dep_word: got %h want 1234beef", word); end
    n_cmp++; if (dictionary[95:0] !== {32'h1234_BEEF, 32'h1234_569A, 32'h1234_5678}) begin n_fail++; $display("FAIL partial_dict: got %h want 1234beef1234569a12345678", dictionary[95:0]); end
    n_cmp++; if (dut.wr_ptr !== 4'd3) begin n_fail++; $display("FAIL partial_wrptr: got %0d want 3", dut.wr_ptr); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send_code(c_lit(i));
      n_cmp++; if (word !== 32'(i)) begin n_fail++; $display("FAIL wrap_lit%0d: got %h want %h", i, word, 32'(i)); end
    end
    n_cmp++; if (dictionary[31:0] !== 32'd16 || dictionary[63:32] !== 32'd1) begin n_fail++; $display("FAIL wrap_dict: got d0=%h d1=%h want 10 1", dictionary[31:0], dictionary[63:32]); end
    n_cmp++; if (dut.wr_ptr !== 4'd1) begin n_fail++; $display("FAIL wrap_wrptr: got %0d want 1", dut.wr_ptr); end
    send_code(c_mmmm(4'd0));
    n_cmp++; if (word !== 32'd16) begin n_fail++; $display("FAIL wrap_mmmm: got %h want 10", word); end
    send_code(c_mmxx(4'd1, 16'hBEEF));
    n_cmp++; if (word !== 32'h0000_BEEF) begin n_fail++; $display("FAIL idx_eq_ptr: got %h want 0000beef", word); end
    n_cmp++; if (dictionary[63:32] !== 32'h0000_BEEF || dut.wr_ptr !== 4'd2) begin n_fail++; $display("FAIL idx_eq_ptr_wr: got d1=%h ptr=%0d want 0000beef 2", dictionary[63:32], dut.wr_ptr); end
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    code_valid = 1'b1;
    code       = c_lit(32'hA1);
    word_ready = 1'b0;
    @(posedge clk);
    #1;
    code = c_lit(32'hA2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (code_ready !== 1'b0 || word_valid !== 1'b1 || word !== 32'hA1) begin n_fail++; $display("FAIL bp_hold%0d: got rdy=%b v=%b %h want 0 1 a1", i, code_ready, word_valid, word); end
    end
    word_ready = 1'b1;
    #1;
    n_cmp++; if (code_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready: got %b want 1", code_ready); end
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    n_cmp++; if (word_valid !== 1'b1 || word !== 32'hA2) begin n_fail++; $display("FAIL bp_next: got v=%b %h want 1 a2", word_valid, word); end
    @(posedge clk);
    #1;
    n_cmp++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", word_valid); end
    n_cmp++; if (dut.wr_ptr !== 4'd2 || dictionary[63:0] !== {32'hA2, 32'hA1}) begin n_fail++; $display("FAIL bp_count: got ptr=%0d %h want 2 000000a2000000a1", dut.wr_ptr, dictionary[63:0]); end
  endtask

  task automatic test_reserved_reset();
    do_reset();
    send_code(c_lit(32'h11));
    send_code({4'b1111, 30'h2AAA_AAAA});
    n_cmp++; if (word !== 32'h0 || err !== 1'b1) begin n_fail++; $display("FAIL rsvd_word: got %h err=%b want 0 err=1", word, err); end
    n_cmp++; if (dictionary !== {480'h0, 32'h11} || dut.wr_ptr !== 4'd1) begin n_fail++; $display("FAIL rsvd_dict: got d0=%h ptr=%0d want 11 1", dictionary[31:0], dut.wr_ptr); end
`ifdef DECOMP_ERR_CNT_EN
    n_cmp++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL rsvd_cnt: got %0d want 1", err_cnt); end
`endif
    send_code(c_lit(32'h22));
    n_cmp++; if (word !== 32'h22 || err !== 1'b0) begin n_fail++; $display("FAIL post_rsvd: got %h err=%b want 22 err=0", word, err); end
    @(negedge clk);
    word_ready = 1'b0;
    code_valid = 1'b1;
    code       = c_lit(32'h33);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (word_valid !== 1'b0 || word !== 32'h0 || dictionary !== 512'h0 || code_ready !== 1'b1) begin n_fail++; $display("FAIL midreset: got v=%b %h rdy=%b d0=%h want 0 0 1 0", word_valid, word, code_ready, dictionary[31:0]); end
    code_valid = 1'b0;
    word_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_literal_mmmm();
    test_zzzz_zzzx();
    test_partial();
    test_wrap();
    test_backpressure();
    test_reserved_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
